// File: rtl/cpu_if_queue.sv
// cpu_if_queue: instruction-fetch stage with a decoupling instruction queue.
//
// The fetch PC goes straight to the I-cache. A hit in the same cycle returns a
// word in memory byte order. That word is byte-swapped into RISC-V order and
// pushed into a DEPTH-entry queue together with its PC and a predicted-taken
// flag. The decoder pops the queue over a valid/ready handshake.
//
// JAL is redirected inside fetch with no bubble. A branch or JALR halts fetch
// until execute supplies the resolved target on redirect_valid/redirect_pc.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; when low, all state holds
//   icache_req/pc   fetch request and word-aligned fetch PC
//   icache_hit/inst same-cycle hit and raw word (byte 0 in [31:24])
//   redirect_*      execute redirect (branch/JALR resolution or flush)
//   out_*           queue head to the decoder (valid/ready handshake)
//
// State  | meaning
// RUN    | fetch active, a word is pushed on every hit with room in the queue
// HALT   | branch/JALR fetched, waiting for the execute redirect

module cpu_if_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_pc,
    input  logic              icache_hit,
    input  logic [31:0]       icache_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_pred_taken
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  mem_pc_q   [DEPTH];
    logic [31:0]        mem_inst_q [DEPTH];
    logic               mem_pred_q [DEPTH];

    logic [31:0]        inst_sw;
    logic [6:0]         opcode;
    logic               is_jal;
    logic               is_halt_op;
    logic [20:0]        jal_imm;
    logic [ADDR_W-1:0]  jal_tgt;
    logic               full;
    logic               running;
    logic               deq;
    logic               fire;
    logic               wr_en;

    assign inst_sw    = {icache_inst[7:0], icache_inst[15:8],
                         icache_inst[23:16], icache_inst[31:24]};
    assign opcode     = inst_sw[6:0];
    assign is_jal     = (opcode == OP_JAL);
    assign is_halt_op = (opcode == OP_BRANCH) || (opcode == OP_JALR);

    assign jal_imm = {inst_sw[31], inst_sw[19:12], inst_sw[20], inst_sw[30:21], 1'b0};
    // Target is re-aligned so icache_pc never carries low address bits.
    assign jal_tgt = (pc_q + {{(ADDR_W-21){jal_imm[20]}}, jal_imm}) & ALIGN_MASK;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign running = (state_q == RUN);

    assign out_valid = rdy && (cnt_q != '0);
    assign deq       = out_valid && out_ready;
    // A full queue still accepts a push when the head leaves the same cycle.
    assign fire      = rdy && running && icache_hit && (!full || deq);
    // A redirect discards any same-cycle push.
    assign wr_en     = fire && !redirect_valid;

    assign icache_req     = rdy && running && !rst;
    assign icache_pc      = pc_q;
    assign out_pc         = mem_pc_q[rptr_q];
    assign out_inst       = out_valid ? mem_inst_q[rptr_q] : NOP;
    assign out_pred_taken = out_valid && mem_pred_q[rptr_q];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (rdy) begin
            if (redirect_valid) begin
                state_d = RUN;
                pc_d    = redirect_pc & ALIGN_MASK;
                wptr_d  = '0;
                rptr_d  = '0;
                cnt_d   = '0;
            end else begin
                if (fire) begin
                    wptr_d = wptr_q + PTR_W'(1);
                    if (is_jal) begin
                        pc_d = jal_tgt;
                    end else begin
                        pc_d = pc_q + ADDR_W'(4);
                    end
                    if (is_halt_op) begin
                        state_d = HALT;
                    end
                end
                if (deq) begin
                    rptr_d = rptr_q + PTR_W'(1);
                end
                if (fire && !deq) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (deq && !fire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC & ALIGN_MASK;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_inst_q[i] <= NOP;
                mem_pred_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            if (wr_en) begin
                mem_pc_q[wptr_q]   <= pc_q;
                mem_inst_q[wptr_q] <= inst_sw;
                mem_pred_q[wptr_q] <= is_jal;
            end
        end
    end

endmodule

// File: tb/tb_cpu_if_queue.sv
// Testbench for cpu_if_queue: directed scenarios with a scoreboard of the
// instructions the decoder is expected to receive, plus direct checks of the
// fetch-side outputs at hand-computed cycles.

module tb_cpu_if_queue;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;
    localparam logic [31:0] NOP      = 32'h13;
    localparam logic [31:0] JAL_40   = 32'h0400_006F;
    localparam logic [31:0] BEQ_8    = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        icache_req;
    logic [31:0] icache_pc;
    logic        icache_hit;
    logic [31:0] icache_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    cpu_if_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .icache_req     (icache_req),
        .icache_pc      (icache_pc),
        .icache_hit     (icache_hit),
        .icache_inst    (icache_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pred_taken (out_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Program image in RISC-V order: JAL +0x40 at 0x200, BEQ at 0x300,
    // elsewhere "addi x1, x0, pc[11:0]" so every word identifies its PC.
    function automatic logic [31:0] prog(input logic [31:0] pc);
        if (pc == 32'h200) return JAL_40;
        if (pc == 32'h300) return BEQ_8;
        return {pc[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    assign icache_inst = swap32(prog(icache_pc));

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.pred = pred;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_one(base + 32'(4 * i), prog(base + 32'(4 * i)), 1'b0);
        end
    endtask

    // Scoreboard monitor: every accepted head is compared with the oldest
    // expectation. Handshakes in a redirect cycle are discarded by the design.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_deq: got pc=%h inst=%h, expected no entry", out_pc, out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc !== mon_e.pc || out_inst !== mon_e.inst || out_pred_taken !== mon_e.pred) begin
                    errors++;
                    $display("FAIL deq_entry: got pc=%h inst=%h pred=%b expected pc=%h inst=%h pred=%b",
                             out_pc, out_inst, out_pred_taken, mon_e.pc, mon_e.inst, mon_e.pred);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        rdy            = 1'b1;
        icache_hit     = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        next();
        next();
        neg();
        chk("rst_icache_pc", icache_pc, 32'h100);
        chk("rst_icache_req", 32'(icache_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, NOP);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pred", 32'(out_pred_taken), 32'd0);
        next();

        // Straight-line stream, one per cycle
        rst = 1'b0;
        push_seq(32'h100, 8);
        for (int k = 0; k < 8; k++) begin
            neg();
            chk("stream_icache_pc", icache_pc, 32'h100 + 32'(4 * k));
            chk("stream_req", 32'(icache_req), 32'd1);
            if (k > 0) chk("stream_out_pc", out_pc, 32'h100 + 32'(4 * (k - 1)));
            next();
        end

        // Decoder stalls: queue fills to DEPTH, fetch holds
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg();
            next();
        end
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("full_icache_pc", icache_pc, 32'h12C);
            chk("full_out_valid", 32'(out_valid), 32'd1);
            chk("full_out_pc", out_pc, 32'h11C);
            next();
        end

        // Pop with a cache miss: three entries remain, PC held
        out_ready  = 1'b1;
        icache_hit = 1'b0;
        neg();
        chk("miss_icache_pc", icache_pc, 32'h12C);
        next();

        // Redirect with hit and deq in the same cycle: both discarded
        icache_hit     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1002;
        neg();
        chk("pre_redir_out_pc", out_pc, 32'h120);
        next();
        redirect_valid = 1'b0;
        push_seq(32'h1000, 4);
        neg();
        chk("redir_out_valid", 32'(out_valid), 32'd0);
        chk("redir_icache_pc", icache_pc, 32'h1000);
        chk("redir_out_inst", out_inst, NOP);
        next();
        neg();
        next();

        // rdy low for three cycles, with an ignored redirect in the middle
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            redirect_valid = (k == 1);
            redirect_pc    = 32'h5550;
            neg();
            chk("frz_out_valid", 32'(out_valid), 32'd0);
            chk("frz_req", 32'(icache_req), 32'd0);
            chk("frz_icache_pc", icache_pc, 32'h1008);
            chk("frz_out_inst", out_inst, NOP);
            next();
        end
        redirect_valid = 1'b0;
        rdy            = 1'b1;
        neg();
        chk("thaw_icache_pc", icache_pc, 32'h1008);
        chk("thaw_out_valid", 32'(out_valid), 32'd1);
        chk("thaw_out_pc", out_pc, 32'h1004);
        next();
        neg();
        next();
        neg();
        next();

        // JAL at 0x200 with offset +0x40
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1F8;
        neg();
        next();
        redirect_valid = 1'b0;
        push_seq(32'h1F8, 2);
        push_one(32'h200, JAL_40, 1'b1);
        push_one(32'h240, prog(32'h240), 1'b0);
        neg();
        chk("jal_pc0", icache_pc, 32'h1F8);
        next();
        neg();
        chk("jal_pc1", icache_pc, 32'h1FC);
        next();
        neg();
        chk("jal_pc2", icache_pc, 32'h200);
        next();
        neg();
        chk("jal_target", icache_pc, 32'h240);
        chk("jal_head_pc", out_pc, 32'h200);
        chk("jal_pred", 32'(out_pred_taken), 32'd1);
        next();
        neg();
        chk("jal_after", icache_pc, 32'h244);
        next();

        // BEQ at 0x300 halts fetch until a redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2FC;
        neg();
        next();
        redirect_valid = 1'b0;
        push_seq(32'h2FC, 1);
        push_one(32'h300, BEQ_8, 1'b0);
        neg();
        chk("br_pc0", icache_pc, 32'h2FC);
        next();
        neg();
        chk("br_pc1", icache_pc, 32'h300);
        chk("br_req1", 32'(icache_req), 32'd1);
        next();
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("halt_req", 32'(icache_req), 32'd0);
            chk("halt_icache_pc", icache_pc, 32'h304);
            if (k > 0) chk("halt_out_valid", 32'(out_valid), 32'd0);
            next();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h304;
        neg();
        chk("halt_req_last", 32'(icache_req), 32'd0);
        next();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        neg();
        chk("resume_icache_pc", icache_pc, 32'h304);
        chk("resume_req", 32'(icache_req), 32'd1);
        next();

        // Fill the queue, then reset mid-stream
        for (int k = 0; k < 3; k++) begin
            neg();
            next();
        end
        rst = 1'b1;
        neg();
        chk("prerst_out_valid", 32'(out_valid), 32'd1);
        chk("prerst_icache_pc", icache_pc, 32'h314);
        chk("prerst_req", 32'(icache_req), 32'd0);
        next();
        rst       = 1'b0;
        out_ready = 1'b1;
        push_seq(32'h100, 2);
        neg();
        chk("midrst_icache_pc", icache_pc, 32'h100);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_inst", out_inst, NOP);
        chk("midrst_out_pc", out_pc, 32'h0);
        chk("midrst_out_pred", 32'(out_pred_taken), 32'd0);
        next();
        neg();
        next();
        icache_hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg();
            next();
        end
        neg();
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
